// File: rtl/optimized_source_fir_filter_if.sv
// Stream bundle for the folded FIR filter: sample input channel plus
// filtered-sample output channel (the output has no back-pressure).
interface optimized_source_fir_filter_if;
  logic        s_axis_data_tvalid;
  logic [15:0] s_axis_data_tdata;
  logic        s_axis_data_tready;
  logic        m_axis_data_tvalid;
  logic [15:0] m_axis_data_tdata;

  modport master (
    output s_axis_data_tvalid,
    output s_axis_data_tdata,
    input  s_axis_data_tready,
    input  m_axis_data_tvalid,
    input  m_axis_data_tdata
  );

  modport slave (
    input  s_axis_data_tvalid,
    input  s_axis_data_tdata,
    output s_axis_data_tready,
    output m_axis_data_tvalid,
    output m_axis_data_tdata
  );
endinterface

// File: rtl/optimized_source_fir_filter.sv
// 8-tap symmetric low-pass FIR with folded tap pairs (4 multipliers).
// Pipeline: delay line -> pre-add -> multiply -> sum -> round/saturate.
module optimized_source_fir_filter #(
  parameter logic signed [15:0] COEF0 = -16'sd512,
  parameter logic signed [15:0] COEF1 = 16'sd0,
  parameter logic signed [15:0] COEF2 = 16'sd4608,
  parameter logic signed [15:0] COEF3 = 16'sd12288
) (
  input logic                          aclk,
  input logic                          areset,
  optimized_source_fir_filter_if.slave axis
);

  logic signed [15:0] taps [8];
  logic signed [16:0] pre  [4];
  logic signed [32:0] prod [4];
  logic signed [35:0] sum;
  logic signed [20:0] scaled;
  logic [3:0]         vld;
  logic               ready;
  logic               accept;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic signed [15:0] sat_data;

  function automatic logic signed [15:0] coef_of(input int j);
    case (j)
      0:       coef_of = COEF0;
      1:       coef_of = COEF1;
      2:       coef_of = COEF2;
      default: coef_of = COEF3;
    endcase
  endfunction

  assign accept = axis.s_axis_data_tvalid & ready;

  // Ready is a register so it only rises on the first edge after reset release.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ready <= 1'b0;
    else        ready <= 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 8; i++) taps[i] <= '0;
    end else if (accept) begin
      taps[0] <= $signed(axis.s_axis_data_tdata);
      for (int i = 1; i < 8; i++) taps[i] <= taps[i-1];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int j = 0; j < 4; j++) begin
        pre[j]  <= '0;
        prod[j] <= '0;
      end
      sum <= '0;
      vld <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        pre[j]  <= 17'(taps[j]) + 17'(taps[7-j]);
        prod[j] <= pre[j] * coef_of(j);
      end
      sum <= 36'(prod[0]) + 36'(prod[1]) + 36'(prod[2]) + 36'(prod[3]);
      vld <= {vld[2:0], accept};
    end
  end

  // Round half up at bit 14, then drop the Q15 fraction and clip to 16 bits.
  assign scaled = 21'((sum + 36'sd16384) >>> 15);

  always_comb begin
    sat_data = scaled[15:0];
    if (scaled > 21'sd32767)       sat_data = 16'sh7FFF;
    else if (scaled < -21'sd32768) sat_data = 16'sh8000;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= vld[3];
      if (vld[3]) out_data <= sat_data;
    end
  end

  assign axis.s_axis_data_tready = ready;
  assign axis.m_axis_data_tvalid = out_valid;
  assign axis.m_axis_data_tdata  = out_data;

endmodule

// File: tb/tb_optimized_source_fir_filter.sv
// Directed bench for the folded FIR: expected samples and accept cycles are
// queued at drive time and matched against each output pulse.
module tb_optimized_source_fir_filter;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  optimized_source_fir_filter_if bus ();

  optimized_source_fir_filter dut (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int value;
    int cyc;
  } exp_t;

  exp_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  int   hist  [8];
  int   coefs [8]  = '{-512, 0, 4608, 12288, 12288, 4608, 0, -512};
  int   imp   [15] = '{-512, 0, 4608, 12288, 12288, 4608, 0, -512, 0, 0, 0, 0, 0, 0, 0};
  int   dc    [16] = '{-16, -16, 125, 500, 875, 1016, 1016, 1000,
                       1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
  int   satp  [12] = '{-512, -512, 4096, 16384, 28671, 32767,
                       32767, 32767, 32767, 32767, 32767, 32767};
  int   satn  [12] = '{512, 512, -4096, -16384, -28672, -32768,
                       -32768, -32768, -32768, -32768, -32768, -32768};

  always @(posedge aclk) cycle <= cycle + 1;

  task automatic check_output(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Direct-form reference: 8 separate multiplies on the bench's own history.
  function automatic int model_push(input int sample);
    longint acc;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sample;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += longint'(coefs[i]) * longint'(hist[i]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic apply_stimulus(input int sample, input bit use_table, input int expected);
    exp_t e;
    int   m;
    @(negedge aclk);
    check_output("tready_at_drive", bus.s_axis_data_tready, 1);
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata  = 16'(sample);
    m       = model_push(sample);
    e.value = use_table ? expected : m;
    e.cyc   = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      bus.s_axis_data_tvalid = 1'b0;
    end
  endtask

  // Reset lands 2 time units after an edge, while traffic may be in flight.
  task automatic do_reset();
    @(posedge aclk);
    #2;
    areset = 1'b1;
    sb.delete();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    #1;
    check_output("rst_m_tvalid", bus.m_axis_data_tvalid, 0);
    check_output("rst_m_tdata", $signed(bus.m_axis_data_tdata), 0);
    check_output("rst_s_tready", bus.s_axis_data_tready, 0);
    bus.s_axis_data_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    check_output("rst_hold_tready", bus.s_axis_data_tready, 0);
    areset = 1'b0;
    @(negedge aclk);
    check_output("post_rst_tready", bus.s_axis_data_tready, 1);
  endtask

  always @(negedge aclk) begin
    exp_t e;
    if (!areset && bus.m_axis_data_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_pulse", bus.m_axis_data_tvalid, 0);
      end else begin
        e = sb.pop_front();
        check_output("tdata", $signed(bus.m_axis_data_tdata), e.value);
        check_output("latency", cycle, e.cyc + 4);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = '0;
    for (int i = 0; i < 8; i++) hist[i] = 0;

    do_reset();

    $display("[TB] impulse");
    for (int i = 0; i < 15; i++) apply_stimulus(i == 0 ? 32767 : 0, 1'b1, imp[i]);
    idle(1);

    $display("[TB] dc step, then reset mid-stream");
    for (int i = 0; i < 16; i++) apply_stimulus(1000, 1'b1, dc[i]);
    do_reset();
    for (int i = 0; i < 15; i++) apply_stimulus(i == 0 ? 32767 : 0, 1'b1, imp[i]);
    idle(1);

    $display("[TB] gapped impulse");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(i == 0 ? 32767 : 0, 1'b1, imp[i]);
      idle($urandom_range(0, 3));
    end
    idle(1);

    $display("[TB] positive saturation");
    for (int i = 0; i < 12; i++) apply_stimulus(32767, 1'b1, satp[i]);
    idle(10);
    check_output("hold_tvalid", bus.m_axis_data_tvalid, 0);
    check_output("hold_tdata", $signed(bus.m_axis_data_tdata), 32767);

    do_reset();
    $display("[TB] negative saturation");
    for (int i = 0; i < 12; i++) apply_stimulus(-32768, 1'b1, satn[i]);

    $display("[TB] random samples against reference model");
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(int'($urandom_range(0, 65535)) - 32768, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(10);
    check_output("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/optimized_source_fir_filter.md
# optimized_source_fir_filter

8-tap symmetric low-pass FIR filter for 16-bit signed audio samples, with AXI4-Stream-style input and output data channels. It sits in the audio path between the sample source and downstream processing, and removes high-frequency noise at a sustained rate of one sample per clock. It is "optimized" by coefficient folding: symmetric tap pairs are pre-added, so only 4 multipliers are needed.

## Interface
Parameters:
- COEF0, default -512: Q1.15 coefficient for taps 0 and 7.
- COEF1, default 0: Q1.15 coefficient for taps 1 and 6.
- COEF2, default 4608: Q1.15 coefficient for taps 2 and 5.
- COEF3, default 12288: Q1.15 coefficient for taps 3 and 4. The default set sums to 32768, giving unity DC gain.

Ports:
- aclk, input, 1: sole clock, rising-edge.
- areset, input, 1: asynchronous, active-high reset.
- s_axis_data_tvalid, input, 1: input sample valid.
- s_axis_data_tdata, input, 16: signed two's-complement input sample.
- s_axis_data_tready, output, 1: input ready.
- m_axis_data_tvalid, output, 1: output sample valid, one-cycle pulse.
- m_axis_data_tdata, output, 16: signed filtered sample.

## Operation
- A sample is accepted at a rising edge where s_axis_data_tvalid=1 and s_axis_data_tready=1.
- Delay line x[0..7]:
  - Shifts only on accepted samples, never on idle cycles.
  - The new sample enters x[0].
  - Reset value of every tap is 0.
- Output equation: y = COEF0·(x0+x7) + COEF1·(x1+x6) + COEF2·(x2+x5) + COEF3·(x3+x4).
- Arithmetic widths:
  - Pre-adds are 17-bit signed.
  - Products are 33-bit signed.
  - Accumulation is 36-bit signed, with no intermediate overflow.
- Result formatting:
  - Add 2^14 (round half up), then arithmetic shift right by 15.
  - Saturate to [-32768, 32767].
- Pipeline registers, in order:
  - delay-line update;
  - pre-add;
  - multiply;
  - sum;
  - round/saturate into the output register.
- Output side:
  - No m_axis tready; the downstream consumer must always accept.
  - m_axis_data_tdata holds its last value between valid pulses.
- Reset (asynchronous, at any time including mid-stream):
  - Clears the delay line, all pipeline data and all in-flight valid bits.
  - Outputs go to m_axis_data_tvalid=0, m_axis_data_tdata=0, s_axis_data_tready=0.
  - Samples in flight at reset assertion are discarded; no valid pulse is produced for them.

## Timing
- s_axis_data_tready:
  - 0 while areset=1.
  - Goes to 1 at the first rising edge after areset deasserts, then stays 1 (fully pipelined, never stalls).
- Latency: a sample accepted at edge k produces m_axis_data_tvalid=1 for exactly the cycle following edge k+4, with the matching m_axis_data_tdata.
- Back-to-back accepts give back-to-back output pulses. Every accepted sample yields exactly one output, in order.
- Idle input cycles (tvalid=0) produce m_axis_data_tvalid=0 four cycles later. Output values are unaffected by the length of input gaps.
- Throughput: 1 sample per clock.

## Test plan
- **Reset:**
  - Stimulus: assert areset mid-cycle with traffic running.
  - Required: all outputs go to 0 immediately (asynchronously).
  - After release: tready=1 at the next edge; the first output after reset reflects a zeroed history.
- **Impulse:**
  - Stimulus: accept 32767, then fourteen 0s.
  - Required outputs: -512, 0, 4608, 12288, 12288, 4608, 0, -512, then 0 thereafter.
  - Each output appears 4 cycles after its input.
- **DC step:**
  - Stimulus: sustained 1000 back-to-back.
  - Required outputs: -16, -16, 125, 500, 875, 1016, 1016, then 1000 steady.
- **Saturation:**
  - Sustained 32767 → 6th and 7th outputs clip to 32767 (unclipped value 33279), then 32767 steady.
  - Sustained -32768 → 6th and 7th outputs clip to -32768 (unclipped value -33280), then -32768 steady.
- **Gapped input:**
  - Stimulus: the impulse sequence sent with 0–3 random idle cycles between samples.
  - Required: identical output value sequence; exactly one m_axis_data_tvalid pulse per accepted sample, each 4 cycles after its accept.
- **Reset mid-stream:**
  - Stimulus: after the DC step reaches 1000, pulse areset for 2 cycles, then apply the impulse.
  - Required: no output pulses from pre-reset samples; the post-reset outputs equal the impulse sequence exactly.
